// File: rtl/vae_pkg.sv
// Shared constants for the level-1 VAE decoder: default sizes, coefficient map, FSM encoding.
package vae_pkg;

    localparam int N_DEF     = 9;
    localparam int WIDTH_DEF = 16;
    localparam int FRAC_DEF  = 8;

    // Coefficient bank layout: W1[0..8], W2[0..8], B[0..8]
    localparam int W1_BASE   = 0;
    localparam int W2_BASE   = 9;
    localparam int B_BASE    = 18;
    localparam int NCOEF     = 27;
    localparam int ADDR_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vae_mac.sv
// Shared signed multiply-accumulate for the VAE decoder; sign of acc+product gives the pixel.
// Optional saturating logit tap enabled by VAE_DECODER_LOGIT_EN.
module vae_mac #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    accum,
    input  logic signed [WIDTH-1:0] coef,
    input  logic signed [WIDTH-1:0] lat,
    input  logic signed [WIDTH-1:0] bias,
    output logic                    pix
`ifdef VAE_DECODER_LOGIT_EN
    ,
    output logic signed [WIDTH-1:0] logit,
    output logic                    logit_valid
`endif
);

    // Two full products plus a shifted bias cannot overflow 2*WIDTH+2 bits.
    localparam int AW = 2 * WIDTH + 2;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      bias_term;
    logic signed [AW-1:0]      sum;
    logic signed [AW-1:0]      acc_reg;

    assign prod      = coef * lat;
    assign bias_term = AW'(bias) <<< FRAC;
    assign sum       = acc_reg + AW'(prod);
    assign pix       = ~sum[AW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (init) begin
            acc_reg <= bias_term + AW'(prod);
        end else if (accum) begin
            acc_reg <= sum;
        end
    end

`ifdef VAE_DECODER_LOGIT_EN
    localparam int LW = AW - FRAC;
    localparam logic signed [LW-1:0] LMAX = LW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [LW-1:0] LMIN = LW'(-(2 ** (WIDTH - 1)));

    logic signed [LW-1:0]    shifted;
    logic signed [WIDTH-1:0] sat_value;
    logic signed [WIDTH-1:0] logit_reg;
    logic                    logit_valid_reg;

    assign shifted = LW'(sum >>> FRAC);

    always_comb begin
        sat_value = WIDTH'(shifted);
        if (shifted > LMAX) begin
            sat_value = WIDTH'(LMAX);
        end else if (shifted < LMIN) begin
            sat_value = WIDTH'(LMIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            logit_reg       <= '0;
            logit_valid_reg <= 1'b0;
        end else begin
            logit_valid_reg <= accum;
            if (accum) begin
                logit_reg <= sat_value;
            end
        end
    end

    assign logit       = logit_reg;
    assign logit_valid = logit_valid_reg;
`endif

endmodule

// File: rtl/vae_decoder.sv
// Serial latent-to-pixel decoder: two MAC phases per pixel over a loadable coefficient bank.
// Define VAE_DECODER_LOGIT_EN to expose the saturated per-pixel logit.
module vae_decoder
    import vae_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a1,
    input  logic signed [WIDTH-1:0] a2,
    input  logic                    start,
    input  logic                    w_we,
    input  logic [ADDR_W-1:0]       w_addr,
    input  logic signed [WIDTH-1:0] w_data,
    output logic [N-1:0]            out,
    output logic                    busy,
    output logic                    done
`ifdef VAE_DECODER_LOGIT_EN
    ,
    output logic signed [WIDTH-1:0] logit,
    output logic                    logit_valid
`endif
);

    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_t                  state_reg;
    logic [IDXW-1:0]         idx_reg;
    logic                    phase_reg;
    logic signed [WIDTH-1:0] a1_reg;
    logic signed [WIDTH-1:0] a2_reg;
    logic [N-1:0]            out_reg;
    logic                    busy_reg;
    logic                    done_reg;

    logic signed [WIDTH-1:0] coef_reg [NCOEF];
    logic [NCOEF-1:0]        wr_sel;
    logic                    wr_ok;

    // Writes are dropped for the whole run so coefficients stay stable.
    assign wr_ok = w_we & ~busy_reg;

    for (genvar gi = 0; gi < NCOEF; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_ok && (w_addr == ADDR_W'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                if (wr_sel[i]) begin
                    coef_reg[i] <= w_data;
                end
            end
        end
    end

    logic [ADDR_W-1:0]       w1_addr;
    logic [ADDR_W-1:0]       w2_addr;
    logic [ADDR_W-1:0]       b_addr;
    logic signed [WIDTH-1:0] mac_coef;
    logic signed [WIDTH-1:0] mac_lat;
    logic                    mac_init;
    logic                    mac_accum;
    logic                    pix;

    assign w1_addr   = ADDR_W'(W1_BASE) + ADDR_W'(idx_reg);
    assign w2_addr   = ADDR_W'(W2_BASE) + ADDR_W'(idx_reg);
    assign b_addr    = ADDR_W'(B_BASE) + ADDR_W'(idx_reg);
    assign mac_init  = (state_reg == RUN) && !phase_reg;
    assign mac_accum = (state_reg == RUN) && phase_reg;
    assign mac_coef  = phase_reg ? coef_reg[w2_addr] : coef_reg[w1_addr];
    assign mac_lat   = phase_reg ? a2_reg : a1_reg;

    vae_mac #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .init       (mac_init),
        .accum      (mac_accum),
        .coef       (mac_coef),
        .lat        (mac_lat),
        .bias       (coef_reg[b_addr]),
        .pix        (pix)
`ifdef VAE_DECODER_LOGIT_EN
        ,
        .logit      (logit),
        .logit_valid(logit_valid)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            phase_reg <= 1'b0;
            a1_reg    <= '0;
            a2_reg    <= '0;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a1_reg    <= a1;
                        a2_reg    <= a2;
                        idx_reg   <= '0;
                        phase_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        out_reg[idx_reg] <= pix;
                        phase_reg        <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: doc/vae_decoder.md
# vae_decoder

Sequential latent-to-pixel decoder for the level-1 VAE: takes the two signed fixed-point latent values produced by the encoder (`a1`, `a2`) and reconstructs the 9-pixel binary 3×3 image. One shared multiply-accumulate datapath walks the pixels serially. Weights and biases are loaded through a small write port, so the same block serves training-derived coefficients and directed test sets. It sits downstream of `encoder` and closes the encode/decode loop in the top level.

## Interface
- `N`, 9: number of output pixels.
- `WIDTH`, 16: latent/weight/bias width, signed two's complement.
- `FRAC`, 8: fractional bits (Q8.8 at defaults).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `a1`  in  WIDTH  latent 1, signed Q8.8; sampled on `start`.
- `a2`  in  WIDTH  latent 2, signed Q8.8; sampled on `start`.
- `start`  in  1  one-cycle request; honoured only when `busy`=0.
- `w_we`  in  1  coefficient write enable; ignored while `busy`=1.
- `w_addr`  in  5  coefficient address. 0–8 are W1[j], 9–17 are W2[j], 18–26 are B[j]. 27–31 are ignored.
- `w_data`  in  WIDTH  coefficient value, signed Q8.8.
- `out`  out  N  reconstructed pixels, `out[j]` = pixel j, LSB = pixel 0.
- `busy`  out  1  high while decoding.
- `done`  out  1  one-cycle pulse when `out` is updated and complete.

## Operation
- Coefficient bank:
  - 27 registers, WIDTH bits each, all reset to 0.
  - A write takes effect on the edge where `w_we`=1.
- Per pixel j, with signed arithmetic throughout:
  - Compute acc = (B[j] sign-extended <<< FRAC) + W1[j]·a1 + W2[j]·a2.
  - Each product is 2·WIDTH bits; acc is 2·WIDTH+2 bits, so no overflow is possible.
  - `out[j]` = 1 iff acc ≥ 0. This is the sigmoid > 0.5 threshold; a tie (acc = 0) gives 1.
- FSM states:
  - IDLE: `start` moves to RUN. Latches a1/a2, sets idx=0, phase=0.
  - RUN phase 0: acc ← bias term + W1[idx]·a1.
  - RUN phase 1: acc + W2[idx]·a2 is thresholded into `out[idx]`. Then idx increments and phase returns to 0. When idx=N−1 the FSM goes to DONE instead.
  - DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `out` holds its previous value until it is overwritten pixel by pixel in the next run. Intermediate bits are not valid until `done`.
- `start` during RUN or DONE is ignored; it is not queued.
- Writes during `busy` are dropped, so coefficients are stable for a whole run.

## Timing
- Reset values:
  - `out`=0, `busy`=0, `done`=0.
  - FSM in IDLE, idx=0, acc=0.
  - All coefficients 0.
- Edge E0 samples `start`. `busy` is high from after E0 through E2N (E18).
- Edge E2N writes `out[N−1]`. `done` is high in the cycle after E2N.
- Latency: `done` appears 2N+1 = 19 cycles after the `start` edge.
- Back-to-back operation: `start` is accepted again in the cycle after `done`. The minimum period is 2N+2 cycles.
- Reset asserted mid-run aborts the run immediately. All state returns to its reset value, including the coefficients.

## Configuration
- `VAE_DECODER_LOGIT_EN`:
  - When defined, adds output ports `logit` (WIDTH, signed) and `logit_valid` (1).
  - `logit_valid` pulses on each phase-1 edge.
  - `logit` = acc >>> FRAC, saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1], for the pixel just written.
  - Both reset to 0.
- Undefined: the ports and saturation logic are absent, and the rest of the behaviour is identical.

## Structure
- Shared package `vae_pkg`:
  - WIDTH/FRAC/N defaults.
  - Coefficient address bases: W1_BASE=0, W2_BASE=9, B_BASE=18.
  - FSM state encoding (IDLE/RUN/DONE).
- Sub-module `vae_mac`: signed multiplier plus accumulator with init/accumulate select. The saturating logit tap is optional inside it, behind the macro.

## Test plan
- Reset: drive `rst`=0 mid-run → `out`=0, `busy`=0 and `done`=0 immediately. A subsequent run with zero coefficients gives `out`=9'h1FF.
- Identity: W1[j]=0x0100, W2[j]=0, B[j]=0; a1=0x0100, a2=0, `start` → `done` exactly 19 cycles later with `out`=9'h1FF.
- Alternating: W1 even j=0x0100, odd j=0xFF00; W2=0; B=0; a1=0x0200 → `out`=9'h155.
- Tie and bias: all weights 0, B[4]=0xFFFF, others 0 → `out`=9'b111101111 (0x1EF).
- Protocol: pulse `start`, then `start` and `w_we` again at cycle 5 → one `done` only at cycle 19, and the write is not applied.
- `VAE_DECODER_LOGIT_EN`: W1=W2=0x7FFF, a1=a2=0x7FFF, B=0 → nine `logit_valid` pulses, each with `logit`=0x7FFF; `out`=9'h1FF.
